kangaroo_sync_gen: RTL and testbench

Video raster timing generator for the Kangaroo board model. It is built from cascaded synchronous 4-bit counter stages and produces the pixel/line counters, blanking and sync signals for the video path. Its active-high sync outputs feed the hex-inverter stage directly downstream, which produces the active-low composite/monitor sync.

---
 rtl/kangaroo_video_pkg.sv | 34 +++
 rtl/kangaroo_sync_gen_ls163.sv | 30 +++
 rtl/kangaroo_sync_gen.sv | 148 ++++++++++++++
 tb/tb_kangaroo_sync_gen.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/kangaroo_video_pkg.sv
// Shared types, default raster timing and helpers for the Kangaroo video timing generator.
package kangaroo_video_pkg;

  localparam int CNT_W   = 9;
  localparam int STAGE_W = 4;
  localparam int STAGES  = 3;

  localparam int DEF_H_TOTAL      = 384;
  localparam int DEF_H_ACTIVE     = 256;
  localparam int DEF_H_SYNC_START = 288;
  localparam int DEF_H_SYNC_WIDTH = 32;
  localparam int DEF_V_TOTAL      = 264;
  localparam int DEF_V_ACTIVE     = 240;
  localparam int DEF_V_SYNC_START = 248;
  localparam int DEF_V_SYNC_WIDTH = 4;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    V_ACT,
    V_FP,
    V_SYNC,
    V_BP
  } vphase_t;

  function automatic int to_int(cnt_t c);
    return {{(32-CNT_W){1'b0}}, c};
  endfunction

  function automatic bit timing_ok(int active, int sync_start, int sync_width, int total);
    return (active <= sync_start) && (sync_start + sync_width <= total) && (total <= 2**CNT_W);
  endfunction

endpackage

// File: rtl/kangaroo_sync_gen_ls163.sv
// 74163-style synchronous 4-bit counter: clear beats load beats count; RCO gated by ENT.
module ls163 (
  input  logic       clk_i,
  input  logic       clr_n_i,
  input  logic       load_n_i,
  input  logic       enp_i,
  input  logic       ent_i,
  input  logic [3:0] d_i,
  output logic [3:0] q_o,
  output logic       rco_o
);

  logic [3:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (!load_n_i)             q_d = d_i;
    else if (enp_i && ent_i)   q_d = q_q + 4'd1;
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!clr_n_i) q_q <= 4'h0;
    else          q_q <= q_d;
  end

  assign q_o   = q_q;
  assign rco_o = ent_i && (q_q == 4'hF);

endmodule

// File: rtl/kangaroo_sync_gen.sv
// Raster timing generator built from cascaded ls163 stages per axis.
// Optional KANGAROO_VBL_IRQ_EN adds the VBL_IRQ start-of-vblank pulse output.
module kangaroo_sync_gen
  import kangaroo_video_pkg::*;
#(
  parameter int H_TOTAL      = DEF_H_TOTAL,
  parameter int H_ACTIVE     = DEF_H_ACTIVE,
  parameter int H_SYNC_START = DEF_H_SYNC_START,
  parameter int H_SYNC_WIDTH = DEF_H_SYNC_WIDTH,
  parameter int V_TOTAL      = DEF_V_TOTAL,
  parameter int V_ACTIVE     = DEF_V_ACTIVE,
  parameter int V_SYNC_START = DEF_V_SYNC_START,
  parameter int V_SYNC_WIDTH = DEF_V_SYNC_WIDTH
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             PIXEL_EN,
  output logic [CNT_W-1:0] HCOUNT,
  output logic [CNT_W-1:0] VCOUNT,
  output logic             HBLANK,
  output logic             VBLANK,
  output logic             HSYNC,
  output logic             VSYNC,
  output logic             LINE_END,
  output logic             FRAME_END
`ifdef KANGAROO_VBL_IRQ_EN
  ,
  output logic             VBL_IRQ
`endif
);

  if (!timing_ok(H_ACTIVE, H_SYNC_START, H_SYNC_WIDTH, H_TOTAL)) begin : g_bad_h
    $error("kangaroo_sync_gen: horizontal timing parameters out of range");
  end
  if (!timing_ok(V_ACTIVE, V_SYNC_START, V_SYNC_WIDTH, V_TOTAL)) begin : g_bad_v
    $error("kangaroo_sync_gen: vertical timing parameters out of range");
  end

  localparam int RAW_W = STAGE_W * STAGES;

  logic [RAW_W-1:0]  h_raw, v_raw;
  logic [STAGES-1:0] h_rco, v_rco, h_ent, v_ent;
  logic              h_last, v_last, v_step, h_load_n, v_load_n;
  cnt_t              h_adv, v_adv;

  logic    hblank_q, hsync_q, line_end_q, frame_end_q;
  logic    hblank_d, hsync_d, line_end_d, frame_end_d;
  vphase_t state_q, state_d;

  assign HCOUNT = h_raw[CNT_W-1:0];
  assign VCOUNT = v_raw[CNT_W-1:0];
  assign h_last = (to_int(HCOUNT) == H_TOTAL - 1);
  assign v_last = (to_int(VCOUNT) == V_TOTAL - 1);

  // The vertical chain steps on the same enabled edge that wraps the line.
  assign v_step   = PIXEL_EN && line_end_q;
  assign h_load_n = !(PIXEL_EN && h_last);
  assign v_load_n = !(PIXEL_EN && frame_end_q);
  assign h_ent    = {h_rco[STAGES-2:0], PIXEL_EN};
  assign v_ent    = {v_rco[STAGES-2:0], v_step};

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    ls163 u_h (
      .clk_i(CLK), .clr_n_i(CLR), .load_n_i(h_load_n), .enp_i(PIXEL_EN), .ent_i(h_ent[i]),
      .d_i(4'h0), .q_o(h_raw[i*STAGE_W +: STAGE_W]), .rco_o(h_rco[i])
    );
    ls163 u_v (
      .clk_i(CLK), .clr_n_i(CLR), .load_n_i(v_load_n), .enp_i(v_step), .ent_i(v_ent[i]),
      .d_i(4'h0), .q_o(v_raw[i*STAGE_W +: STAGE_W]), .rco_o(v_rco[i])
    );
  end

  logic unused_carry;
  assign unused_carry = ^{h_raw[RAW_W-1:CNT_W], v_raw[RAW_W-1:CNT_W], h_rco[STAGES-1], v_rco[STAGES-1]};

  // Counter values after an enabled edge; flags are derived from these so they line up with the counts.
  always_comb begin
    h_adv = h_last ? '0 : HCOUNT + cnt_t'(1);
    v_adv = VCOUNT;
    if (h_last) v_adv = v_last ? '0 : VCOUNT + cnt_t'(1);
  end

  // NOTE: every _d gets its hold value first, so no branch can leave it unassigned and infer a latch.
  always_comb begin
    hblank_d    = hblank_q;
    hsync_d     = hsync_q;
    line_end_d  = line_end_q;
    frame_end_d = frame_end_q;
    state_d     = state_q;
    if (PIXEL_EN) begin
      hblank_d    = to_int(h_adv) >= H_ACTIVE;
      hsync_d     = (to_int(h_adv) >= H_SYNC_START) && (to_int(h_adv) < H_SYNC_START + H_SYNC_WIDTH);
      line_end_d  = to_int(h_adv) == H_TOTAL - 1;
      frame_end_d = (to_int(h_adv) == H_TOTAL - 1) && (to_int(v_adv) == V_TOTAL - 1);
    end
    if (v_step) begin
      unique case (state_q)
        V_ACT:   if (to_int(v_adv) == V_SYNC_START) state_d = V_SYNC;
                 else if (to_int(v_adv) == V_ACTIVE) state_d = V_FP;
        V_FP:    if (to_int(v_adv) == V_SYNC_START) state_d = V_SYNC;
        V_SYNC:  if (v_adv == '0) state_d = V_ACT;
                 else if (to_int(v_adv) == V_SYNC_START + V_SYNC_WIDTH) state_d = V_BP;
        V_BP:    if (v_adv == '0) state_d = V_ACT;
        default: state_d = V_ACT;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!CLR) begin
      hblank_q    <= 1'b0;
      hsync_q     <= 1'b0;
      line_end_q  <= 1'b0;
      frame_end_q <= 1'b0;
      state_q     <= V_ACT;
    end else begin
      hblank_q    <= hblank_d;
      hsync_q     <= hsync_d;
      line_end_q  <= line_end_d;
      frame_end_q <= frame_end_d;
      state_q     <= state_d;
    end
  end

  assign HBLANK    = hblank_q;
  assign HSYNC     = hsync_q;
  assign LINE_END  = line_end_q;
  assign FRAME_END = frame_end_q;
  assign VBLANK    = (state_q != V_ACT);
  assign VSYNC     = (state_q == V_SYNC);

`ifdef KANGAROO_VBL_IRQ_EN
  logic irq_q, irq_d;

  always_comb begin
    irq_d = irq_q;
    if (PIXEL_EN) irq_d = v_step && (to_int(v_adv) == V_ACTIVE);
  end

  always_ff @(posedge CLK) begin
    if (!CLR) irq_q <= 1'b0;
    else      irq_q <= irq_d;
  end

  assign VBL_IRQ = irq_q;
`endif

endmodule

// File: tb/tb_kangaroo_sync_gen.sv
// Bench for kangaroo_sync_gen: a default-timing instance and a shrunken-timing instance
// run side by side against a counter-level reference model.
module tb_kangaroo_sync_gen;

  typedef struct packed {
    logic [8:0] h;
    logic [8:0] v;
    logic [6:0] f;  // {hblank, vblank, hsync, vsync, line_end, frame_end, irq}
  } obs_t;

  typedef struct {
    int ht, ha, hss, hsw, vt, va, vss, vsw;
  } timing_t;

  localparam int SM_HT = 48, SM_HA = 32, SM_HSS = 36, SM_HSW = 4;
  localparam int SM_VT = 33, SM_VA = 24, SM_VSS = 26, SM_VSW = 3;

  logic clk = 1'b0;
  logic clr_n;
  logic pix_en;
  always #5 clk = ~clk;

  int      n_checks = 0;
  int      n_errors = 0;
  timing_t cfg [2];
  int      mh [2];
  int      mv [2];
  bit      mirq [2];
  obs_t    obs [2];

  logic [8:0] hc0, vc0, hc1, vc1;
  logic hb0, vb0, hs0, vs0, le0, fe0, irq0;
  logic hb1, vb1, hs1, vs1, le1, fe1, irq1;

  kangaroo_sync_gen u_dut_std (
    .CLK(clk), .CLR(clr_n), .PIXEL_EN(pix_en),
    .HCOUNT(hc0), .VCOUNT(vc0), .HBLANK(hb0), .VBLANK(vb0), .HSYNC(hs0), .VSYNC(vs0),
    .LINE_END(le0), .FRAME_END(fe0)
`ifdef KANGAROO_VBL_IRQ_EN
    , .VBL_IRQ(irq0)
`endif
  );

  kangaroo_sync_gen #(
    .H_TOTAL(SM_HT), .H_ACTIVE(SM_HA), .H_SYNC_START(SM_HSS), .H_SYNC_WIDTH(SM_HSW),
    .V_TOTAL(SM_VT), .V_ACTIVE(SM_VA), .V_SYNC_START(SM_VSS), .V_SYNC_WIDTH(SM_VSW)
  ) u_dut_small (
    .CLK(clk), .CLR(clr_n), .PIXEL_EN(pix_en),
    .HCOUNT(hc1), .VCOUNT(vc1), .HBLANK(hb1), .VBLANK(vb1), .HSYNC(hs1), .VSYNC(vs1),
    .LINE_END(le1), .FRAME_END(fe1)
`ifdef KANGAROO_VBL_IRQ_EN
    , .VBL_IRQ(irq1)
`endif
  );

`ifndef KANGAROO_VBL_IRQ_EN
  assign irq0 = 1'b0;
  assign irq1 = 1'b0;
`endif

  assign obs[0] = {hc0, vc0, hb0, vb0, hs0, vs0, le0, fe0, irq0};
  assign obs[1] = {hc1, vc1, hb1, vb1, hs1, vs1, le1, fe1, irq1};

  // Reference: plain position counters; every flag is a predicate on the position.
  task automatic model_edge(input logic clr, input logic en);
    for (int k = 0; k < 2; k++) begin
      if (!clr) begin
        mh[k] = 0; mv[k] = 0; mirq[k] = 1'b0;
      end else if (en) begin
        mh[k]++;
        if (mh[k] == cfg[k].ht) begin
          mh[k] = 0;
          mv[k]++;
          if (mv[k] == cfg[k].vt) mv[k] = 0;
        end
`ifdef KANGAROO_VBL_IRQ_EN
        mirq[k] = (mh[k] == 0) && (mv[k] == cfg[k].va);
`endif
      end
    end
  endtask

  function automatic obs_t expect_of(int k);
    obs_t e;
    bit   le;
    le   = (mh[k] == cfg[k].ht - 1);
    e.h  = 9'(mh[k]);
    e.v  = 9'(mv[k]);
    e.f  = {mh[k] >= cfg[k].ha,
            mv[k] >= cfg[k].va,
            (mh[k] >= cfg[k].hss) && (mh[k] < cfg[k].hss + cfg[k].hsw),
            (mv[k] >= cfg[k].vss) && (mv[k] < cfg[k].vss + cfg[k].vsw),
            le,
            le && (mv[k] == cfg[k].vt - 1),
            mirq[k]};
    return e;
  endfunction

  task automatic check_obs(input string tag, input int k);
    obs_t e;
    e = expect_of(k);
    n_checks++;
    assert (obs[k] === e) else begin
      n_errors++;
      $error("FAIL %s dut%0d: got h=%0d v=%0d flags=%b, expected h=%0d v=%0d flags=%b",
             tag, k, obs[k].h, obs[k].v, obs[k].f, e.h, e.v, e.f);
    end
  endtask

  task automatic check_int(input string tag, input logic [31:0] got, input int exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input logic clr, input logic en);
    clr_n  = clr;
    pix_en = en;
    @(posedge clk);
    model_edge(clr, en);
    #1;
    for (int k = 0; k < 2; k++) check_obs(tag, k);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int v_prev, len, pulses;
    cfg[0] = '{384, 256, 288, 32, 264, 240, 248, 4};
    cfg[1] = '{SM_HT, SM_HA, SM_HSS, SM_HSW, SM_VT, SM_VA, SM_VSS, SM_VSW};
    for (int k = 0; k < 2; k++) begin
      mh[k] = 0; mv[k] = 0; mirq[k] = 1'b0;
    end
    clr_n  = 1'b0;
    pix_en = 1'b0;

    // Clear held for three edges with the enable asserted: clear must win.
    for (int i = 0; i < 3; i++) step("reset", 1'b0, 1'b1);
    check_int("reset_h", hc0, 0);
    check_int("reset_flags", {hb0, vb0, hs0, vs0, le0, fe0, irq0}, 0);

    step("first_edge", 1'b1, 1'b1);
    check_int("first_h_std", hc0, 1);
    check_int("first_h_small", hc1, 1);
    check_int("first_v", vc0, 0);

    for (int i = 0; i < 4000; i++) step("random", 1'b1, $urandom_range(3) != 0);

    // HSYNC window on the default-timing instance.
    for (int i = 0; i < 500 && hc0 !== 9'd287; i++) step("seek", 1'b1, 1'b1);
    check_int("seek_287", hc0, 287);
    check_int("hsync_at_287", hs0, 0);
    step("hsync", 1'b1, 1'b1);
    check_int("hsync_at_288", hs0, 1);
    for (int i = 0; i < 31; i++) step("hsync", 1'b1, 1'b1);
    check_int("hsync_h319", hc0, 319);
    check_int("hsync_at_319", hs0, 1);
    step("hsync", 1'b1, 1'b1);
    check_int("hsync_at_320", hs0, 0);

    // Stall at end of line, then wrap.
    for (int i = 0; i < 500 && le0 !== 1'b1; i++) step("seek", 1'b1, 1'b1);
    check_int("line_end_h", hc0, 383);
    v_prev = int'(vc0);
    for (int i = 0; i < 10; i++) step("stall", 1'b1, 1'b0);
    check_int("stall_h", hc0, 383);
    check_int("stall_line_end", le0, 1);
    step("line_wrap", 1'b1, 1'b1);
    check_int("wrap_h", hc0, 0);
    check_int("wrap_v", vc0, (v_prev + 1) % 264);
    check_int("wrap_line_end", le0, 0);

    // Frame wrap and frame length on the small instance.
    for (int i = 0; i < 2000 && fe1 !== 1'b1; i++) step("seek", 1'b1, 1'b1);
    check_int("frame_end_flag", fe1, 1);
    check_int("frame_end_h", hc1, SM_HT - 1);
    check_int("frame_end_v", vc1, SM_VT - 1);
    step("frame_wrap", 1'b1, 1'b1);
    check_int("frame_wrap_hv", {hc1, vc1}, 0);
    check_int("frame_wrap_vblank", vb1, 0);
    len = 1;
    pulses = 0;
    while (fe1 !== 1'b1 && len < 3000) begin
      step("frame", 1'b1, 1'b1);
      len++;
      if (irq1 === 1'b1) pulses++;
    end
    check_int("frame_len", len, SM_HT * SM_VT);
`ifdef KANGAROO_VBL_IRQ_EN
    check_int("irq_per_frame", pulses, 1);
`endif

    // Mid-frame clear.
    for (int i = 0; i < 3000 && vc1 !== 9'd10; i++) step("seek", 1'b1, $urandom_range(3) != 0);
    check_int("seek_v10", vc1, 10);
    step("mid_reset", 1'b0, 1'b1);
    check_int("mid_reset_small", {hc1, vc1, hb1, vb1, hs1, vs1, le1, fe1, irq1}, 0);
    check_int("mid_reset_std", {hc0, vc0, hb0, vb0, hs0, vs0, le0, fe0, irq0}, 0);

    for (int i = 0; i < 200; i++) step("post_reset", 1'b1, $urandom_range(3) != 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
